// File: rtl/fp_addsub_pipe.sv
// ---------------------------------------------------------------------------
// fp_addsub_pipe
//
// Three-stage pipelined floating-point adder/subtractor with parametrised
// exponent and fraction widths. Subnormal inputs are flushed to zero and
// subnormal results are flushed to zero with underflow flagged. Rounding is
// round-to-nearest-even.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand pair valid
//   in_ready   block accepts operands this cycle
//   a, b       operands {sign, exponent, fraction}
//   op_sub     0 = a + b, 1 = a - b
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   result     packed result
//   flags      {invalid, overflow, underflow, inexact}
//
// Handshake: an input transfer happens on a rising edge where
// in_valid && in_ready; an output transfer happens on a rising edge where
// out_valid && out_ready. The only stall condition is an unaccepted output
// (out_valid && !out_ready); it freezes every stage, so in_ready is simply
// its inverse and is the one combinational path from out_ready.
// ---------------------------------------------------------------------------
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic                   op_sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [3:0]             flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    // Aligned significand: hidden, fraction, guard, round, sticky.
    localparam int SW   = MAN_W + 4;
    localparam int LZ_W = $clog2(SW + 1);
    // Signed working width for the exponent so that normalisation below
    // zero and overflow above all-ones are both representable.
    localparam int XW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [31:0]      SH_LIM   = 32'(MAN_W + 3);

    logic stall;
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // ------------------------------------------------------------------
    // S1: unpack, classify, order by magnitude, align
    // ------------------------------------------------------------------
    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [MAN_W-1:0]   a_frac, b_frac;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic               sign_a, sign_b;

    assign a_exp  = a[W-2:MAN_W];
    assign b_exp  = b[W-2:MAN_W];
    assign a_frac = a[MAN_W-1:0];
    assign b_frac = b[MAN_W-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
    assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
    assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
    assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);
    assign sign_a = a[W-1];
    assign sign_b = b[W-1] ^ op_sub;

    logic [W-2:0]       mag_a, mag_b, big_mag, small_mag;
    logic               big_sign;
    logic [EXP_W-1:0]   big_exp, small_exp, exp_diff;
    logic [MAN_W:0]     big_sig, small_sig;
    logic [SW-2:0]      small_ext, shifted, lost, keep_mask;
    logic [SW-1:0]      big_al, small_al;
    logic               spec_c;
    logic [W-1:0]       spec_res_c;
    logic [3:0]         spec_flags_c;

    always_comb begin
        // Flushed subnormals compare as zero magnitude.
        mag_a = a_zero ? '0 : a[W-2:0];
        mag_b = b_zero ? '0 : b[W-2:0];

        if (mag_b > mag_a) begin
            big_mag   = mag_b;
            small_mag = mag_a;
            big_sign  = sign_b;
        end else begin
            big_mag   = mag_a;
            small_mag = mag_b;
            big_sign  = sign_a;
        end

        big_exp   = big_mag[W-2:MAN_W];
        small_exp = small_mag[W-2:MAN_W];
        big_sig   = (big_exp == '0)   ? '0 : {1'b1, big_mag[MAN_W-1:0]};
        small_sig = (small_exp == '0) ? '0 : {1'b1, small_mag[MAN_W-1:0]};
        exp_diff  = big_exp - small_exp;

        small_ext = {small_sig, 2'b00};
        keep_mask = '1;
        shifted   = '0;
        lost      = '0;
        if (32'(exp_diff) >= SH_LIM) begin
            // Everything falls below the round bit; only sticky survives.
            small_al = {{(SW-1){1'b0}}, |small_sig};
        end else begin
            shifted  = small_ext >> exp_diff;
            lost     = small_ext & ~(keep_mask << exp_diff);
            small_al = {shifted, |lost};
        end
        big_al = {big_sig, 3'b000};

        spec_c       = 1'b1;
        spec_res_c   = '0;
        spec_flags_c = 4'b0000;
        if (a_nan || b_nan) begin
            spec_res_c = QNAN;
        end else if (a_inf && b_inf && (sign_a != sign_b)) begin
            spec_res_c   = QNAN;
            spec_flags_c = 4'b1000;
        end else if (a_inf) begin
            spec_res_c = {sign_a, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_res_c = {sign_b, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            // Only -0 + -0 keeps the negative sign.
            spec_res_c = {sign_a & sign_b, {(W-1){1'b0}}};
        end else begin
            spec_c = 1'b0;
        end
    end

    logic               s1_valid, s1_special, s1_sign, s1_sub;
    logic [W-1:0]       s1_spec_res;
    logic [3:0]         s1_spec_flags;
    logic [EXP_W-1:0]   s1_exp;
    logic [SW-1:0]      s1_big, s1_small;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_special    <= 1'b0;
            s1_spec_res   <= '0;
            s1_spec_flags <= '0;
            s1_sign       <= 1'b0;
            s1_sub        <= 1'b0;
            s1_exp        <= '0;
            s1_big        <= '0;
            s1_small      <= '0;
        end else if (!stall) begin
            s1_valid      <= in_valid;
            s1_special    <= spec_c;
            s1_spec_res   <= spec_res_c;
            s1_spec_flags <= spec_flags_c;
            s1_sign       <= big_sign;
            s1_sub        <= sign_a ^ sign_b;
            s1_exp        <= big_exp;
            s1_big        <= big_al;
            s1_small      <= small_al;
        end
    end

    // ------------------------------------------------------------------
    // S2: magnitude add / subtract (big >= small, so no negative result)
    // ------------------------------------------------------------------
    logic [SW:0] sum_c;
    assign sum_c = s1_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                          : ({1'b0, s1_big} + {1'b0, s1_small});

    logic               s2_valid, s2_special, s2_sign;
    logic [W-1:0]       s2_spec_res;
    logic [3:0]         s2_spec_flags;
    logic [EXP_W-1:0]   s2_exp;
    logic [SW:0]        s2_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid      <= 1'b0;
            s2_special    <= 1'b0;
            s2_spec_res   <= '0;
            s2_spec_flags <= '0;
            s2_sign       <= 1'b0;
            s2_exp        <= '0;
            s2_sum        <= '0;
        end else if (!stall) begin
            s2_valid      <= s1_valid;
            s2_special    <= s1_special;
            s2_spec_res   <= s1_spec_res;
            s2_spec_flags <= s1_spec_flags;
            s2_sign       <= s1_sign;
            s2_exp        <= s1_exp;
            s2_sum        <= sum_c;
        end
    end

    // ------------------------------------------------------------------
    // S3: normalise, round to nearest even, pack
    // ------------------------------------------------------------------
    logic [LZ_W-1:0]    lzc;
    logic               lz_found;
    logic [XW-1:0]      exp_x, exp_n, exp_r, exp_ones_x;
    logic [SW-1:0]      norm;
    logic               g_bit, r_bit, s_bit, rnd_up, inexact_c;
    logic [MAN_W:0]     mant;
    logic [MAN_W+1:0]   rounded;
    logic [MAN_W-1:0]   frac_r;
    logic [W-1:0]       res_c;
    logic [3:0]         flags_c;

    assign exp_x      = {{(XW-EXP_W){1'b0}}, s2_exp};
    assign exp_ones_x = {{(XW-EXP_W){1'b0}}, EXP_ONES};

    always_comb begin
        lzc      = LZ_W'(SW);
        lz_found = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!lz_found && s2_sum[i]) begin
                lzc      = LZ_W'(SW - 1 - i);
                lz_found = 1'b1;
            end
        end

        if (s2_sum[SW]) begin
            // Carry out: shift right one, folding the dropped bit into sticky.
            norm  = {s2_sum[SW:2], s2_sum[1] | s2_sum[0]};
            exp_n = exp_x + XW'(1);
        end else begin
            norm  = s2_sum[SW-1:0] << lzc;
            exp_n = exp_x - {{(XW-LZ_W){1'b0}}, lzc};
        end

        mant      = norm[SW-1:3];
        g_bit     = norm[2];
        r_bit     = norm[1];
        s_bit     = norm[0];
        inexact_c = g_bit | r_bit | s_bit;
        rnd_up    = g_bit & (r_bit | s_bit | mant[0]);
        rounded   = {1'b0, mant} + (MAN_W+2)'(rnd_up);

        if (rounded[MAN_W+1]) begin
            // Rounding overflowed the hidden bit: mantissa becomes 1.000...
            frac_r = rounded[MAN_W:1];
            exp_r  = exp_n + XW'(1);
        end else begin
            frac_r = rounded[MAN_W-1:0];
            exp_r  = exp_n;
        end

        res_c   = {s2_sign, exp_r[EXP_W-1:0], frac_r};
        flags_c = {3'b000, inexact_c};
        if (s2_special) begin
            res_c   = s2_spec_res;
            flags_c = s2_spec_flags;
        end else if (s2_sum == '0) begin
            // Exact cancellation always yields +0.
            res_c   = '0;
            flags_c = 4'b0000;
        end else if (exp_n[XW-1] || (exp_n == '0)) begin
            res_c   = {s2_sign, {(W-1){1'b0}}};
            flags_c = 4'b0011;
        end else if (!exp_r[XW-1] && (exp_r >= exp_ones_x)) begin
            res_c   = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
            flags_c = 4'b0101;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (!stall) begin
            out_valid <= s2_valid;
            // Result keeps its last value across bubbles.
            if (s2_valid) begin
                result <= res_c;
                flags  <= flags_c;
            end
        end
    end

endmodule
